// File: rtl/mdu_pkg.sv
// Shared divider types and constants: FSM state encoding and the default operand width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mdu_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// One unsigned restoring iteration: shift {rem,quo} left one bit, subtract the divisor if it fits.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit keeps the shifted remainder exact; diff[WIDTH] set means it did not fit.
    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    assign remOut = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 DIV/DIVU for EX: holds the pipeline via stall, flags HI/LO with done.
// Latency: WIDTH+1 cycles from the first start cycle to the first done cycle.
// Backpressure: DONE holds hi/lo stable until accept; cancel aborts from any state.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic             accept,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    divState_t        state;
    logic [5:0]       iterCnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             quoNeg;
    logic             remNeg;

    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic             negA;
    logic             negB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign negA = is_signed & dividend[WIDTH-1];
    assign negB = is_signed & divisor[WIDTH-1];
    assign absA = negA ? (~dividend + 1'b1) : dividend;
    assign absB = negB ? (~divisor + 1'b1) : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (rem),
        .quoIn   (quo),
        .divisor (dvsr),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Combinational so the hazard unit freezes the pipe in the very cycle start appears.
    assign stall = ((state == IDLE) && start && !cancel) || (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            iterCnt <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            quoNeg  <= 1'b0;
            remNeg  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem     <= '0;
                        quo     <= absA;
                        dvsr    <= absB;
                        quoNeg  <= negA ^ negB;
                        remNeg  <= negA;
                        iterCnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    rem     <= stepRem;
                    quo     <= stepQuo;
                    iterCnt <= iterCnt + 1'b1;
                    if (iterCnt == LAST_STEP) begin
                        hi    <= remNeg ? (~stepRem + 1'b1) : stepRem;
                        lo    <= quoNeg ? (~stepQuo + 1'b1) : stepQuo;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: constant vectors, random ops against an arithmetic model,
// and hand sequences for cancel, held DONE and mid-operation reset.
module tb_mdu_divider;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        accept;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mdu_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (isSigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .accept    (accept),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: divide magnitudes, divide-by-zero gives all ones / dividend, then apply signs.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [31:0] am;
        logic [31:0] bm;
        logic [31:0] q;
        logic [31:0] r;
        am = (sg && a[31]) ? (32'd0 - a) : a;
        bm = (sg && b[31]) ? (32'd0 - b) : b;
        if (bm == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = am;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        el = (sg && (a[31] ^ b[31])) ? (32'd0 - q) : q;
        eh = (sg && a[31]) ? (32'd0 - r) : r;
    endfunction

    // Entered just after a rising edge; returns at the falling edge of the first done cycle.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic acc);
        int lat;
        start    = 1'b1;
        isSigned = sg;
        dividend = a;
        divisor  = b;
        accept   = acc;
        @(negedge clk);
        chk("stall_cycle0", 32'(stall), 32'd1);
        chk("done_cycle0", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 33);
    endtask

    task automatic checkRelease(input string name);
        start = 1'b0;
        @(negedge clk);
        chk({name, "_stall"}, 32'(stall), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        tick();
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        sawDone;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd2,         32'd14};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD};
        vecs[3] = '{32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF};

        resetn = 1'b0; start = 1'b0; isSigned = 1'b0;
        dividend = '0; divisor = '0; cancel = 1'b0; accept = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        resetn = 1'b1;
        tick();

        // Back-to-back table ops: each new start follows the done cycle with no bubble.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sg, 1'b1);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
            tick();
        end
        checkRelease("table_release");

        // Cancel in BUSY cycle 10.
        start = 1'b1; isSigned = 1'b0; dividend = 32'd1000; divisor = 32'd3; accept = 1'b1;
        repeat (10) tick();
        cancel = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        chk("cancel_stall_busy", 32'(stall), 32'd1);
        tick();
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_idle_stall", 32'(stall), 32'd0);
        chk("cancel_hi_kept", hi, vecs[5].expHi);
        chk("cancel_lo_kept", lo, vecs[5].expLo);
        sawDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sawDone = sawDone | done;
        end
        chk("cancel_no_done", 32'(sawDone), 32'd0);
        tick();
        launch(32'd1000, 32'd3, 1'b0, 1'b1);
        chk("after_cancel_hi", hi, 32'd1);
        chk("after_cancel_lo", lo, 32'd333);
        tick();
        checkRelease("cancel_release");

        // DONE held for three cycles with accept low and start still high.
        launch(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                tick();
                @(negedge clk);
            end
            chk($sformatf("hold%0d_done", k), 32'(done), 32'd1);
            chk($sformatf("hold%0d_stall", k), 32'(stall), 32'd1);
            chk($sformatf("hold%0d_hi", k), hi, 32'hFFFF_FFFF);
            chk($sformatf("hold%0d_lo", k), lo, 32'hFFFF_FFFD);
        end
        tick();
        accept = 1'b1;
        @(negedge clk);
        chk("hold_accept_done", 32'(done), 32'd1);
        tick();
        checkRelease("hold_release");

        // Reset asserted in BUSY cycle 15.
        start = 1'b1; isSigned = 1'b0; dividend = 32'd1000; divisor = 32'd7;
        repeat (15) tick();
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        launch(32'd9, 32'd3, 1'b0, 1'b1);
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd3);
        tick();
        checkRelease("postrst_release");

        // Random back-to-back ops against the model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom_range(0, 3);
                1: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
                2: rb = $urandom_range(1, 65535);
                default: rb = $urandom;
            endcase
            if (i % 7 == 3) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, eh, el);
            launch(ra, rb, rs, 1'b1);
            chk($sformatf("rand%0d_hi", i), hi, eh);
            chk($sformatf("rand%0d_lo", i), lo, el);
            tick();
        end
        checkRelease("rand_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
